// File: rtl/mem_access_unit.sv
// Load/store initiator: turns byte/halfword/word requests into aligned word accesses,
// doing read-modify-write for sub-word stores and sign/zero extension for loads.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata
);

  // state    | meaning
  // S_IDLE   | ready for a request
  // S_RD     | load read of the addressed word
  // S_RMW_RD | read half of a sub-word store; merged word built at the edge
  // S_WR     | write of the merged word
  // S_RESP   | one-cycle response pulse
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_req_err;
  logic        w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_req_err = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)              w_next = S_RESP;
          else if (!req_write)        w_next = S_RD;
          else if (req_size == 2'b10) w_next = S_WR;
          else                        w_next = S_RMW_RD;
        end
      end
      S_RD: begin
        mem_read = 1'b1;
        w_next   = S_RESP;
      end
      S_RMW_RD: begin
        mem_read = 1'b1;
        w_next   = S_WR;
      end
      S_WR: begin
        mem_write = 1'b1;
        w_next    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Little-endian lane extraction and merge on the raw memory word
  always_comb begin
    w_byte   = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half   = mem_rdata[{r_addr[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
    w_merged = mem_rdata;
    if (r_size == 2'b00) w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else                 w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_pc     <= 32'h0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      if (w_accept) begin
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_pc     <= req_pc;
        r_err    <= w_req_err;
      end
      // r_wdata doubles as the merged store word once the old word is read
      if (r_state == S_RMW_RD) r_wdata <= w_merged;
      if (w_next == S_RESP) r_rdata <= (r_state == S_RD) ? w_load : 32'h0;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = (r_state == S_RESP) && r_err;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = r_wdata;
  assign mem_pc     = r_pc;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory, per-request behavioural model checked every cycle,
// and directed transactions with hand-computed literal results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_pc(mem_pc), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem_arr [0:63] = '{default: 32'h0};
  logic [31:0] ref_mem [0:63] = '{default: 32'h0};
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'h0;

  assign mem_rdata = mem_arr[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en)          mem_arr[pl_idx] <= pl_val;
    else if (mem_write) mem_arr[mem_addr[7:2]] <= mem_wdata;
  end

  int checks = 0, failures = 0, cyc = 0, resp_cnt = 0, acc_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  typedef struct {
    int          due;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] pc;
  } req_t;
  req_t q[$];

  function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int lat_of(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (is_err(sz, a)) return 1;
    if (!w || sz == 2'd2) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a[1:0]);
      v = (word >> sh) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'(a[1]);
      v = (word >> sh) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else v = word;
    return v;
  endfunction

  function automatic logic [31:0] exp_store(input logic [1:0] sz, input logic [31:0] a,
                                            input logic [31:0] d, input logic [31:0] old);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd2) return d;
    sh   = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  always @(posedge clk) begin
    req_t e;
    cyc++;
    if (reset) q.delete();
    else if (req_valid && req_ready) begin
      e.due = cyc + lat_of(req_write, req_size, req_addr) - 1;
      e.w = req_write; e.sz = req_size; e.sg = req_signed;
      e.a = req_addr;  e.d = req_wdata; e.pc = req_pc;
      q.push_back(e);
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    req_t f;
    logic [5:0] widx;
    logic ferr;
    if (pl_en) ref_mem[pl_idx] = pl_val;
    if (!reset) begin
      chk("rw_mutex", 32'(mem_read & mem_write), 32'd0);
      if (q.size() == 0) begin
        chk("idle_mem_rd", 32'(mem_read), 32'd0);
        chk("idle_mem_wr", 32'(mem_write), 32'd0);
        chk("idle_resp", 32'(resp_valid), 32'd0);
      end else begin
        f = q[0];
        widx = f.a[7:2];
        ferr = is_err(f.sz, f.a);
        if (ferr) chk("err_no_mem", 32'({mem_read, mem_write}), 32'd0);
        else begin
          if (mem_read) begin
            chk("rd_kind", 32'(!f.w || f.sz != 2'd2), 32'd1);
            chk("rd_addr", mem_addr, {f.a[31:2], 2'b00});
            chk("rd_pc", mem_pc, f.pc);
          end
          if (mem_write) begin
            chk("wr_kind", 32'(f.w), 32'd1);
            chk("wr_addr", mem_addr, {f.a[31:2], 2'b00});
            chk("wr_data", mem_wdata, exp_store(f.sz, f.a, f.d, ref_mem[widx]));
            chk("wr_pc", mem_pc, f.pc);
          end
        end
        if (cyc == f.due) begin
          resp_cnt++;
          chk("resp_valid", 32'(resp_valid), 32'd1);
          chk("resp_err", 32'(resp_err), 32'(ferr));
          chk("resp_rdata", resp_rdata,
              (ferr || f.w) ? 32'h0 : exp_load(f.sz, f.sg, f.a, ref_mem[widx]));
          if (!ferr && f.w) ref_mem[widx] = exp_store(f.sz, f.a, f.d, ref_mem[widx]);
          void'(q.pop_front());
        end else chk("resp_early", 32'(resp_valid), 32'd0);
      end
    end
  end

  // ---- directed helpers ----
  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_idx = idx[5:0]; pl_val = v; pl_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                        output logic [31:0] rd, output logic e, output int lat,
                        output int rd_n, output int wr_n, output int rd_k, output int wr_k,
                        output logic [31:0] wa, output logic [31:0] wd);
    int g;
    rd = 32'h0; e = 1'b0; lat = -1; rd_n = 0; wr_n = 0; rd_k = 0; wr_k = 0; wa = 32'h0; wd = 32'h0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d; req_pc = pc;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_read) begin rd_n++; rd_k = k; end
      if (mem_write) begin wr_n++; wr_k = k; wa = mem_addr; wd = mem_wdata; end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; e = resp_err;
        break;
      end
    end
  endtask

  logic [31:0] t_rd, t_wa, t_wd;
  logic        t_e;
  int          t_lat, t_rn, t_wn, t_rk, t_wk;
  int          resp0, acc0;

  typedef struct {
    logic w; logic [1:0] sz; logic sg; logic [31:0] a; logic [31:0] d; logic [31:0] rd;
  } vec_t;

  vec_t loads[4] = '{
    '{1'b0, 2'd0, 1'b1, 32'h32, 32'h0, 32'hFFFFFFFF},
    '{1'b0, 2'd0, 1'b0, 32'h32, 32'h0, 32'h000000FF},
    '{1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 32'hFFFF80FF},
    '{1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 32'h00007F01}
  };
  vec_t errs[3] = '{
    '{1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 32'h0},
    '{1'b1, 2'd1, 1'b0, 32'h23, 32'h1234, 32'h0},
    '{1'b0, 2'd3, 1'b0, 32'h30, 32'h0, 32'h0}
  };
  vec_t b2b[4] = '{
    '{1'b1, 2'd1, 1'b0, 32'h42, 32'h0000BEEF, 32'h0},
    '{1'b0, 2'd1, 1'b1, 32'h42, 32'h0, 32'h0},
    '{1'b1, 2'd0, 1'b0, 32'h41, 32'h0000005A, 32'h0},
    '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0}
  };

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_rd", 32'(mem_read), 32'd0);
    chk("rst_mem_wr", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_pc", mem_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_ready", 32'(req_ready), 32'd1);

    // Reset asserted while the FSM is writing: the write must be suppressed
    preload(4, 32'h01234567);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
    req_pc = 32'h44; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 chk("pre_rst_in_wr", 32'(mem_write), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_mem_wr", 32'(mem_write), 32'd0);
    chk("abort_mem_rd", 32'(mem_read), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_mem_pc", mem_pc, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_no_write", mem_arr[4], 32'h01234567);

    // Word path
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h100, t_rd, t_e, t_lat, t_rn, t_wn, t_rk, t_wk, t_wa, t_wd);
    chk("sw_lat", 32'(t_lat), 32'd2);
    chk("sw_wr_n", 32'(t_wn), 32'd1);
    chk("sw_rd_n", 32'(t_rn), 32'd0);
    chk("sw_addr", t_wa, 32'h10);
    chk("sw_rdata", t_rd, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h104, t_rd, t_e, t_lat, t_rn, t_wn, t_rk, t_wk, t_wa, t_wd);
    chk("lw_lat", 32'(t_lat), 32'd2);
    chk("lw_rdata", t_rd, 32'hDEADBEEF);

    // Byte store read-modify-write
    preload(8, 32'h11223344);
    do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 32'h108, t_rd, t_e, t_lat, t_rn, t_wn, t_rk, t_wk, t_wa, t_wd);
    chk("sb_lat", 32'(t_lat), 32'd3);
    chk("sb_rd_k", 32'(t_rk), 32'd1);
    chk("sb_wr_k", 32'(t_wk), 32'd2);
    chk("sb_wdata", t_wd, 32'h11AA3344);
    chk("sb_mem", mem_arr[8], 32'h11AA3344);

    // Load extension
    preload(12, 32'h80FF7F01);
    foreach (loads[i]) begin
      do_req(loads[i].w, loads[i].sz, loads[i].sg, loads[i].a, loads[i].d, 32'h200 + 32'(i * 4),
             t_rd, t_e, t_lat, t_rn, t_wn, t_rk, t_wk, t_wa, t_wd);
      chk($sformatf("ld%0d_lat", i), 32'(t_lat), 32'd2);
      chk($sformatf("ld%0d_rdata", i), t_rd, loads[i].rd);
    end

    // Rejected requests
    foreach (errs[i]) begin
      do_req(errs[i].w, errs[i].sz, errs[i].sg, errs[i].a, errs[i].d, 32'h300,
             t_rd, t_e, t_lat, t_rn, t_wn, t_rk, t_wk, t_wa, t_wd);
      chk($sformatf("err%0d_lat", i), 32'(t_lat), 32'd1);
      chk($sformatf("err%0d_flag", i), 32'(t_e), 32'd1);
      chk($sformatf("err%0d_rdata", i), t_rd, 32'h0);
      chk($sformatf("err%0d_mem", i), 32'(t_rn + t_wn), 32'd0);
    end
    chk("err_mem_intact", mem_arr[8], 32'h11AA3344);

    // Back-to-back with req_valid held high
    preload(16, 32'h55667788);
    resp0 = resp_cnt;
    acc0  = acc_cnt;
    foreach (b2b[i]) begin
      int g;
      @(negedge clk);
      req_write = b2b[i].w; req_size = b2b[i].sz; req_signed = b2b[i].sg;
      req_addr = b2b[i].a; req_wdata = b2b[i].d; req_pc = 32'h400 + 32'(i * 4);
      req_valid = 1'b1;
      g = 0;
      while (!req_ready && g < 20) begin
        @(negedge clk);
        g++;
      end
      chk($sformatf("b2b%0d_ready", i), 32'(req_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd4);
    chk("b2b_resps", 32'(resp_cnt - resp0), 32'd4);
    chk("b2b_mem", mem_arr[16], 32'hBEEF5A88);
    chk("queue_drained", 32'(q.size()), 32'd0);

    for (int i = 0; i < 64; i++) chk($sformatf("mem_final_%0d", i), mem_arr[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
